// File: rtl/exc_sequencer.sv
// Multi-channel interrupt sequencer for the 5-stage MIPS pipeline: pending latches,
// fixed-priority selection, delay-slot-safe acceptance and EXL/ERET handshaking toward CP0.
module exc_sequencer #(
    parameter int               N_IRQ       = 6,
    parameter logic [N_IRQ-1:0] EDGE_MASK   = {N_IRQ{1'b0}},
    parameter int               RET_HOLDOFF = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] im,
    input  logic             ie,
    input  logic             id_valid,
    input  logic             id_uncertain_jump,
    input  logic             id_jmp,
    input  logic             id_eret,
    input  logic             stall,
    output logic             exl_set,
    output logic             exl_clr,
    output logic             if_flush,
    output logic             npc_from_epc,
    output logic             exl,
    output logic [3:0]       irq_id,
    output logic [N_IRQ-1:0] ip
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] HANDLER = 2'd2;
    localparam logic [1:0] RETURN  = 2'd3;
    localparam logic [2:0] HOLD_INIT = 3'(RET_HOLDOFF);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [2:0]       holdoff;
    logic [2:0]       holdoff_nxt;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] pend_nxt;
    logic [N_IRQ-1:0] irq_d;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] take_mask;
    logic             exl_q;
    logic [3:0]       irq_id_q;
    logic [3:0]       win_idx;
    logic             prev_br;
    logic             advance;
    logic             safe;
    logic             req;
    logic             accept;
    logic             retire;

    // An instruction is interruptible only when it really leaves ID and is neither
    // a control transfer, an ERET, nor the delay slot of the previous one.
    assign advance = id_valid & ~stall;
    assign safe    = advance & ~id_uncertain_jump & ~id_jmp & ~id_eret & ~prev_br;
    assign active  = pend & im;
    assign req     = ie & ~exl_q & (holdoff == 3'd0) & (|active);
    assign accept  = ((state == IDLE) | (state == ARMED)) & req & safe;
    // ERET is forwarded in any state since CP0 owns EPC; gated so reset forces it low.
    assign retire  = reset & id_eret & advance;

    always_comb begin
        win_idx = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) win_idx = 4'(i);
        end
    end

    // Edge channels are sticky until taken; a new edge in the take cycle survives.
    always_comb begin
        take_mask = '0;
        pend_nxt  = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            take_mask[i] = accept && (win_idx == 4'(i));
            if (EDGE_MASK[i])
                pend_nxt[i] = (irq[i] & ~irq_d[i]) | (pend[i] & ~take_mask[i]);
            else
                pend_nxt[i] = irq[i];
        end
    end

    always_comb begin
        state_nxt   = state;
        holdoff_nxt = holdoff;
        case (state)
            IDLE: begin
                if (req) state_nxt = safe ? HANDLER : ARMED;
            end
            ARMED: begin
                if (!req)      state_nxt = IDLE;
                else if (safe) state_nxt = HANDLER;
            end
            HANDLER: begin
                if (retire) begin
                    state_nxt   = RETURN;
                    holdoff_nxt = HOLD_INIT;
                end
            end
            default: begin
                if (holdoff <= 3'd1) state_nxt = IDLE;
                holdoff_nxt = (holdoff == 3'd0) ? 3'd0 : holdoff - 3'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            holdoff  <= 3'd0;
            pend     <= '0;
            irq_d    <= '0;
            exl_q    <= 1'b0;
            irq_id_q <= 4'd0;
            prev_br  <= 1'b0;
        end else begin
            state   <= state_nxt;
            holdoff <= holdoff_nxt;
            pend    <= pend_nxt;
            irq_d   <= irq;
            if (accept) begin
                exl_q    <= 1'b1;
                irq_id_q <= win_idx;
            end else if (retire) begin
                exl_q <= 1'b0;
            end
            if (advance) prev_br <= id_uncertain_jump | id_jmp;
        end
    end

    assign exl_set      = accept;
    assign if_flush     = accept;
    assign exl_clr      = retire;
    assign npc_from_epc = retire;
    assign exl          = exl_q;
    assign irq_id       = accept ? win_idx : irq_id_q;
    assign ip           = pend;

endmodule
